clip_distortion_engine: RTL

- Sample-processing datapath driven by the guitar_effect RAM-mailbox controller.
- The controller latches gain, boost and bypass from shared RAM and presents one input sample at a time.
- The engine applies gain, a symmetric hard clip and output boost, then holds the result until the controller collects it and writes it back to RAM.
- Handshaked and multi-cycle, so the controller polls a level-held valid instead of sampling an edge.

---
 rtl/clip_distortion_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clip_distortion_engine.sv
// clip_distortion_engine: gain -> symmetric hard clip -> boost on one signed
// sample at a time. The result is held with a level valid until the mailbox
// controller acknowledges it.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | in_ready=1, waiting for a sample (bypass returns in 1 edge)
// S_GAIN  | sample x gain, shift, saturate into r_g
// S_CLIP  | clamp r_g to +/-T, count clamps
// S_BOOST | clipped value x boost, shift, saturate into out_sample
// S_HOLD  | out_valid held until out_ack
module clip_distortion_engine #(
    parameter int FRAC_BITS = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bypass,
    input  logic [31:0]      gain,
    input  logic [31:0]      boost,
    input  logic [31:0]      threshold,
    input  logic             in_valid,
    input  logic [31:0]      in_sample,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_sample,
    input  logic             out_ack,
    output logic [CNT_W-1:0] clip_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAIN,
        S_CLIP,
        S_BOOST,
        S_HOLD
    } state_t;

    localparam logic signed [63:0] MAX64 = 64'sd2147483647;
    localparam logic signed [63:0] MIN64 = -64'sd2147483648;
    localparam logic signed [31:0] MAX32 = 32'sh7FFFFFFF;

    state_t             r_state;
    logic signed [31:0] r_sample;
    logic        [31:0] r_gain;
    logic        [31:0] r_boost;
    logic        [31:0] r_thresh;
    logic signed [31:0] r_g;

    logic signed [31:0] w_mul_a;
    logic        [31:0] w_mul_b;
    logic signed [63:0] w_prod;
    logic signed [63:0] w_shift;
    logic signed [31:0] w_sat;
    logic signed [31:0] w_t;
    logic signed [31:0] w_neg_t;
    logic               w_clip_hi;
    logic               w_clip_lo;

    assign in_ready = (r_state == S_IDLE);

    // One multiplier shared by the gain and boost stages; the gain word is
    // zero-extended so the product stays signed.
    always_comb begin
        w_mul_a = (r_state == S_BOOST) ? r_g : r_sample;
        w_mul_b = (r_state == S_BOOST) ? r_boost : r_gain;
        w_prod  = $signed({{32{w_mul_a[31]}}, w_mul_a}) * $signed({32'd0, w_mul_b});
        w_shift = w_prod >>> FRAC_BITS;
        if (w_shift > MAX64)
            w_sat = MAX32;
        else if (w_shift < MIN64)
            w_sat = 32'sh80000000;
        else
            w_sat = w_shift[31:0];
    end

    // Clip limit: thresholds above 2^31-1 are pinned so -T is always representable.
    always_comb begin
        w_t       = r_thresh[31] ? MAX32 : $signed(r_thresh);
        w_neg_t   = -w_t;
        w_clip_hi = (r_g > w_t);
        w_clip_lo = (r_g < w_neg_t);
    end

    // Sequencer with registered result, valid and saturating clip counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sample   <= '0;
            r_gain     <= '0;
            r_boost    <= '0;
            r_thresh   <= '0;
            r_g        <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            clip_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sample <= in_sample;
                        r_gain   <= gain;
                        r_boost  <= boost;
                        r_thresh <= threshold;
                        if (bypass) begin
                            out_sample <= in_sample;
                            out_valid  <= 1'b1;
                            r_state    <= S_HOLD;
                        end else begin
                            r_state <= S_GAIN;
                        end
                    end
                end
                S_GAIN: begin
                    r_g     <= w_sat;
                    r_state <= S_CLIP;
                end
                S_CLIP: begin
                    if (w_clip_hi)
                        r_g <= w_t;
                    else if (w_clip_lo)
                        r_g <= w_neg_t;
                    if ((w_clip_hi || w_clip_lo) && !(&clip_count))
                        clip_count <= clip_count + CNT_W'(1);
                    r_state <= S_BOOST;
                end
                S_BOOST: begin
                    out_sample <= w_sat;
                    out_valid  <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
